// File: rtl/tree_pkg.sv
// rtl/tree_pkg.sv - shared types for the protobuf tag decoder
package tree_pkg;

    localparam int FIELD_ID_W = 5;

    typedef enum logic [2:0] {
        VARINT = 3'd0,
        I64    = 3'd1,
        LEN    = 3'd2,
        I32    = 3'd5
    } wire_type_e;

    typedef struct packed {
        logic [FIELD_ID_W-1:0] field_id;
        logic [2:0]            wire_type;
    } tag_t;

    typedef enum logic [2:0] {
        ERR_NONE        = 3'd0,
        ERR_BAD_WT      = 3'd1,
        ERR_FIELD_RANGE = 3'd2,
        ERR_KEY_LONG    = 3'd3,
        ERR_LEN_OVF     = 3'd4,
        ERR_TRUNC       = 3'd5,
        ERR_VARINT_LONG = 3'd6
    } tag_err_e;

    typedef enum logic [2:0] {
        ST_KEY, ST_VAL, ST_LEN, ST_FIX, ST_PAY, ST_ERR
    } state_e;

    function automatic logic wt_supported(input logic [2:0] wt);
        return (wt == VARINT) || (wt == I64) || (wt == LEN) || (wt == I32);
    endfunction

endpackage

// File: rtl/tree_varint_acc.sv
// rtl/tree_varint_acc.sv - 7-bit-group varint accumulator with done/overflow flags
// Outputs reflect the byte presented this cycle; state clears itself after done or overflow.
module tree_varint_acc #(
    parameter int W         = 14,
    parameter int MAX_BYTES = 2
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clear_i,
    input  logic         byte_valid_i,
    input  logic [7:0]   byte_i,
    output logic [W-1:0] value_o,
    output logic         done_o,
    output logic         overflow_o
);
    localparam int WIDE_W = 7 * MAX_BYTES + 1;
    localparam int SH_W   = $clog2(WIDE_W);
    localparam int CNT_W  = $clog2(MAX_BYTES + 1);

    logic [W-1:0]      acc_q, acc_d;
    logic [SH_W-1:0]   sh_q, sh_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WIDE_W-1:0] grp;
    logic              last_slot;

    always_comb begin
        grp        = WIDE_W'(byte_i[6:0]) << sh_q;
        value_o    = acc_q | grp[W-1:0];
        last_slot  = (cnt_q == CNT_W'(MAX_BYTES - 1));
        done_o     = byte_valid_i && !byte_i[7];
        // Bits landing above W, or a continuation on the final permitted byte.
        overflow_o = byte_valid_i && ((|(grp >> W)) || (last_slot && byte_i[7]));
        acc_d = acc_q;
        sh_d  = sh_q;
        cnt_d = cnt_q;
        if (clear_i || done_o || overflow_o) begin
            acc_d = '0;
            sh_d  = '0;
            cnt_d = '0;
        end else if (byte_valid_i) begin
            acc_d = value_o;
            sh_d  = sh_q + SH_W'(7);
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q <= '0;
            sh_q  <= '0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            sh_q  <= sh_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/tree_tag_decoder.sv
// rtl/tree_tag_decoder.sv - protobuf byte stream to tag events plus per-field payload bytes
// Optional TREE_TAG_DECODER_STATS_EN adds saturating tag_count_o / err_count_o.
module tree_tag_decoder
    import tree_pkg::*;
#(
    parameter int LEN_W            = 16,
    parameter int MAX_VARINT_BYTES = 10
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic [7:0]            in_data_i,
    input  logic                  in_valid_i,
    input  logic                  in_last_i,
    output logic                  in_ready_o,
    output logic [FIELD_ID_W-1:0] tag_field_id_o,
    output logic [2:0]            tag_wire_type_o,
    output logic                  tag_valid_o,
    input  logic                  tag_ready_i,
    output logic [7:0]            data_o,
    output logic                  data_valid_o,
    output logic                  data_last_o,
    input  logic                  data_ready_i,
    output logic                  err_o,
    output logic [2:0]            err_code_o
`ifdef TREE_TAG_DECODER_STATS_EN
    ,
    output logic [15:0]           tag_count_o,
    output logic [7:0]            err_count_o
`endif
);
    localparam int VCNT_W = $clog2(MAX_VARINT_BYTES + 1);

    state_e            state_q, state_d;
    tag_t              tag_q, tag_d;
    logic              tag_valid_q, tag_valid_d;
    logic [7:0]        data_q, data_d;
    logic              data_valid_q, data_valid_d;
    logic              data_last_q, data_last_d;
    logic              err_q, err_d;
    tag_err_e          err_code_q, err_code_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic [VCNT_W-1:0] vcnt_q, vcnt_d;

    logic              rdy, accept, det, emit, emit_last;
    tag_err_e          det_code;
    logic [13:0]       key_value;
    logic              key_done, key_ovf;
    logic [LEN_W-1:0]  len_value;
    logic              len_done, len_ovf;
    logic [10:0]       key_field;
    logic [2:0]        key_wt;

    assign accept    = in_valid_i && rdy;
    assign key_field = key_value[13:3];
    assign key_wt    = key_value[2:0];

    tree_varint_acc #(.W(14), .MAX_BYTES(2)) u_key_acc (
        .clk_i        (clk_i),
        .rst_ni       (reset_i),
        .clear_i      ((state_q != ST_KEY) || (accept && in_last_i)),
        .byte_valid_i (accept && (state_q == ST_KEY)),
        .byte_i       (in_data_i),
        .value_o      (key_value),
        .done_o       (key_done),
        .overflow_o   (key_ovf)
    );

    tree_varint_acc #(.W(LEN_W), .MAX_BYTES(3)) u_len_acc (
        .clk_i        (clk_i),
        .rst_ni       (reset_i),
        .clear_i      ((state_q != ST_LEN) || (accept && in_last_i)),
        .byte_valid_i (accept && (state_q == ST_LEN)),
        .byte_i       (in_data_i),
        .value_o      (len_value),
        .done_o       (len_done),
        .overflow_o   (len_ovf)
    );

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) state_q <= ST_KEY;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d      = state_q;
        rem_d        = rem_q;
        vcnt_d       = vcnt_q;
        tag_d        = tag_q;
        tag_valid_d  = tag_valid_q && !tag_ready_i;
        data_d       = data_q;
        data_valid_d = data_valid_q && !data_ready_i;
        data_last_d  = data_last_q;
        det          = 1'b0;
        det_code     = ERR_NONE;
        emit         = 1'b0;
        emit_last    = 1'b0;
        if (accept) begin
            case (state_q)
                ST_KEY: begin
                    if (key_ovf) begin
                        det = 1'b1; det_code = ERR_KEY_LONG;
                    end else if (key_done) begin
                        if (key_field == 11'd0 || key_field > 11'd31) begin
                            det = 1'b1; det_code = ERR_FIELD_RANGE;
                        end else if (!wt_supported(key_wt)) begin
                            det = 1'b1; det_code = ERR_BAD_WT;
                        end else begin
                            tag_valid_d     = 1'b1;
                            tag_d.field_id  = key_value[7:3];
                            tag_d.wire_type = key_wt;
                            vcnt_d          = '0;
                            case (key_wt)
                                VARINT:  state_d = ST_VAL;
                                I64:     begin state_d = ST_FIX; rem_d = LEN_W'(8); end
                                I32:     begin state_d = ST_FIX; rem_d = LEN_W'(4); end
                                default: state_d = ST_LEN;
                            endcase
                            if (in_last_i) begin
                                det = 1'b1; det_code = ERR_TRUNC;
                            end
                        end
                    end else if (in_last_i) begin
                        det = 1'b1; det_code = ERR_TRUNC;
                    end
                end
                ST_VAL: begin
                    if (vcnt_q == VCNT_W'(MAX_VARINT_BYTES - 1) && in_data_i[7]) begin
                        det = 1'b1; det_code = ERR_VARINT_LONG;
                    end else begin
                        emit      = 1'b1;
                        emit_last = !in_data_i[7] || in_last_i;
                        vcnt_d    = vcnt_q + 1'b1;
                        if (!in_data_i[7]) state_d = ST_KEY;
                        else if (in_last_i) begin
                            det = 1'b1; det_code = ERR_TRUNC;
                        end
                    end
                end
                ST_FIX, ST_PAY: begin
                    emit      = 1'b1;
                    emit_last = (rem_q == LEN_W'(1)) || in_last_i;
                    rem_d     = rem_q - 1'b1;
                    if (rem_q == LEN_W'(1)) state_d = ST_KEY;
                    else if (in_last_i) begin
                        det = 1'b1; det_code = ERR_TRUNC;
                    end
                end
                ST_LEN: begin
                    if (len_ovf) begin
                        det = 1'b1; det_code = ERR_LEN_OVF;
                    end else if (len_done && len_value == '0) begin
                        state_d = ST_KEY;
                    end else if (in_last_i) begin
                        det = 1'b1; det_code = ERR_TRUNC;
                    end else if (len_done) begin
                        state_d = ST_PAY;
                        rem_d   = len_value;
                    end
                end
                ST_ERR:  if (in_last_i) state_d = ST_KEY;
                default: state_d = ST_KEY;
            endcase
            // A detection on the message's final byte has nothing left to discard.
            if (det) state_d = in_last_i ? ST_KEY : ST_ERR;
        end
        if (emit) begin
            data_valid_d = 1'b1;
            data_d       = in_data_i;
            data_last_d  = emit_last;
        end
        if (state_q == ST_ERR) begin
            err_d      = !(accept && in_last_i);
            err_code_d = err_d ? err_code_q : ERR_NONE;
        end else begin
            err_d      = 1'b0;
            err_code_d = ERR_NONE;
        end
        if (det) begin
            err_d      = 1'b1;
            err_code_d = det_code;
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            tag_q        <= '0;
            tag_valid_q  <= 1'b0;
            data_q       <= '0;
            data_valid_q <= 1'b0;
            data_last_q  <= 1'b0;
            err_q        <= 1'b0;
            err_code_q   <= ERR_NONE;
            rem_q        <= '0;
            vcnt_q       <= '0;
        end else begin
            tag_q        <= tag_d;
            tag_valid_q  <= tag_valid_d;
            data_q       <= data_d;
            data_valid_q <= data_valid_d;
            data_last_q  <= data_last_d;
            err_q        <= err_d;
            err_code_q   <= err_code_d;
            rem_q        <= rem_d;
            vcnt_q       <= vcnt_d;
        end
    end

    always_comb begin
        case (state_q)
            ST_KEY:  rdy = !tag_valid_q || tag_ready_i;
            ST_ERR:  rdy = 1'b1;
            default: rdy = !data_valid_q || data_ready_i;
        endcase
        rdy             = rdy && reset_i;
        in_ready_o      = rdy;
        tag_field_id_o  = tag_q.field_id;
        tag_wire_type_o = tag_q.wire_type;
        tag_valid_o     = tag_valid_q;
        data_o          = data_q;
        data_valid_o    = data_valid_q;
        data_last_o     = data_last_q;
        err_o           = err_q;
        err_code_o      = err_code_q;
    end

`ifdef TREE_TAG_DECODER_STATS_EN
    logic [15:0] tag_count_q, tag_count_d;
    logic [7:0]  err_count_q, err_count_d;

    always_comb begin
        tag_count_d = tag_count_q;
        err_count_d = err_count_q;
        if (tag_valid_q && tag_ready_i && tag_count_q != 16'hFFFF) tag_count_d = tag_count_q + 16'd1;
        if (det && err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            tag_count_q <= '0;
            err_count_q <= '0;
        end else begin
            tag_count_q <= tag_count_d;
            err_count_q <= err_count_d;
        end
    end

    assign tag_count_o = tag_count_q;
    assign err_count_o = err_count_q;
`endif

endmodule
